// File: rtl/fpga_rst_seq.sv
// fpga_rst_seq: staged reset sequencer for the 20 MHz system domain.
// Qualifies the synchronised MMCM lock, releases active-low stage resets one
// at a time, then raises sys_ready and blinks a heartbeat. Lock loss or a
// software request drops every stage again; lock losses in RUN are counted.
module fpga_rst_seq #(
   parameter int STAGES      = 4,
   parameter int LOCK_STABLE = 1024,
   parameter int STAGE_GAP   = 16,
   parameter int SOFT_HOLD   = 64,
   parameter int HB_DIV      = 10000000
) (
   input  logic              fpga_clk,
   input  logic              fpga_rst,
   input  logic              pll_locked,
   input  logic              soft_rst_req,
   output logic [STAGES-1:0] rst_n,
   output logic              sys_ready,
   output logic              heartbeat,
   output logic [7:0]        fault_cnt
);

   // One counter width covers every interval, sized from the largest one.
   localparam int M1   = (LOCK_STABLE > STAGE_GAP) ? LOCK_STABLE : STAGE_GAP;
   localparam int M2   = (M1 > SOFT_HOLD) ? M1 : SOFT_HOLD;
   localparam int MAXP = (M2 > HB_DIV) ? M2 : HB_DIV;
   localparam int CW   = $clog2(MAXP) + 1;

   localparam logic [STAGES-1:0] STG_ONE   = STAGES'(1);
   localparam logic [CW-1:0]     STABLE_N  = CW'(LOCK_STABLE);
   localparam logic [CW-1:0]     GAP_LAST  = CW'(STAGE_GAP - 1);
   localparam logic [CW-1:0]     HOLD_LAST = CW'(SOFT_HOLD - 1);
   localparam logic [CW-1:0]     HB_LAST   = CW'(HB_DIV - 1);

   typedef enum logic [1:0] {WAIT_LOCK, RELEASE, RUN, SOFT} state_t;

   state_t            state_q;
   logic [1:0]        sync_q;
   logic              lock_s;
   logic [CW-1:0]     cnt_q;     // stable count / stage gap / soft hold
   logic [CW-1:0]     hb_cnt_q;
   logic [STAGES-1:0] rst_n_q;
   logic              rdy_q;
   logic              hb_q;
   logic [7:0]        fault_q;

   // Two-flop synchroniser for the asynchronous lock flag.
   always_ff @(posedge fpga_clk or posedge fpga_rst) begin
      if (fpga_rst) sync_q <= 2'b00;
      else          sync_q <= {sync_q[0], pll_locked};
   end

   assign lock_s = sync_q[1];

   // Sequencer FSM with registered reset, ready, heartbeat and fault outputs.
   always_ff @(posedge fpga_clk or posedge fpga_rst) begin
      if (fpga_rst) begin
         state_q  <= WAIT_LOCK;
         cnt_q    <= '0;
         hb_cnt_q <= '0;
         rst_n_q  <= '0;
         rdy_q    <= 1'b0;
         hb_q     <= 1'b0;
         fault_q  <= 8'd0;
      end else if (state_q == WAIT_LOCK) begin
         rst_n_q  <= '0;
         rdy_q    <= 1'b0;
         hb_q     <= 1'b0;
         hb_cnt_q <= '0;
         if (!lock_s) begin
            cnt_q <= '0;
         end else if (cnt_q == STABLE_N) begin
            state_q <= RELEASE;
            rst_n_q <= STG_ONE;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end else if (!lock_s) begin
         // Lock loss beats a simultaneous soft request.
         state_q  <= WAIT_LOCK;
         cnt_q    <= '0;
         hb_cnt_q <= '0;
         rst_n_q  <= '0;
         rdy_q    <= 1'b0;
         hb_q     <= 1'b0;
         if (state_q == RUN && fault_q != 8'hFF) fault_q <= fault_q + 8'd1;
      end else if (soft_rst_req && state_q != SOFT) begin
         state_q  <= SOFT;
         cnt_q    <= '0;
         hb_cnt_q <= '0;
         rst_n_q  <= '0;
         rdy_q    <= 1'b0;
         hb_q     <= 1'b0;
      end else begin
         case (state_q)
            RELEASE: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q <= '0;
                  if (rst_n_q[STAGES-1]) begin
                     state_q <= RUN;
                     rdy_q   <= 1'b1;
                  end else begin
                     rst_n_q <= (rst_n_q << 1) | STG_ONE;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RUN: begin
               if (hb_cnt_q == HB_LAST) begin
                  hb_cnt_q <= '0;
                  hb_q     <= ~hb_q;
               end else begin
                  hb_cnt_q <= hb_cnt_q + 1'b1;
               end
            end
            SOFT: begin
               // Lock is still good, so go straight back to releasing.
               if (cnt_q == HOLD_LAST) begin
                  state_q <= RELEASE;
                  rst_n_q <= STG_ONE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= WAIT_LOCK;
         endcase
      end
   end

   assign rst_n     = rst_n_q;
   assign sys_ready = rdy_q;
   assign heartbeat = hb_q;
   assign fault_cnt = fault_q;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// tb_fpga_rst_seq: directed stimulus, per-cycle comparison against a
// phase/elapsed-time model, plus literal timing expectations.
module tb_fpga_rst_seq;

   localparam int NS   = 4;
   localparam int LS   = 8;
   localparam int GAP  = 4;
   localparam int HOLD = 6;
   localparam int HBD  = 5;

   localparam int PH_WAIT = 0;
   localparam int PH_REL  = 1;
   localparam int PH_RUN  = 2;
   localparam int PH_SOFT = 3;

   logic          fpga_clk = 1'b0;
   logic          fpga_rst = 1'b1;
   logic          pll_locked = 1'b0;
   logic          soft_rst_req = 1'b0;
   logic [NS-1:0] rst_n;
   logic          sys_ready;
   logic          heartbeat;
   logic [7:0]    fault_cnt;

   int checks = 0;
   int errors = 0;
   int cur = 0;

   fpga_rst_seq #(
      .STAGES(NS), .LOCK_STABLE(LS), .STAGE_GAP(GAP), .SOFT_HOLD(HOLD), .HB_DIV(HBD)
   ) dut (
      .fpga_clk(fpga_clk), .fpga_rst(fpga_rst), .pll_locked(pll_locked),
      .soft_rst_req(soft_rst_req), .rst_n(rst_n), .sys_ready(sys_ready),
      .heartbeat(heartbeat), .fault_cnt(fault_cnt)
   );

   always #5 fpga_clk = ~fpga_clk;

   // Model: phase plus cycles elapsed since entering it.
   int         m_ph, m_el, m_stab, m_fault;
   logic [1:0] m_sync;

   always @(posedge fpga_clk or posedge fpga_rst) begin
      if (fpga_rst) begin
         m_ph <= PH_WAIT; m_el <= 0; m_stab <= 0; m_fault <= 0; m_sync <= 2'b00;
      end else begin
         m_sync <= {m_sync[0], pll_locked};
         if (m_ph == PH_WAIT) begin
            if (!m_sync[1]) m_stab <= 0;
            else if (m_stab == LS) begin m_ph <= PH_REL; m_el <= 0; m_stab <= 0; end
            else m_stab <= m_stab + 1;
         end else if (!m_sync[1]) begin
            if (m_ph == PH_RUN && m_fault < 255) m_fault <= m_fault + 1;
            m_ph <= PH_WAIT; m_stab <= 0;
         end else if (soft_rst_req && m_ph != PH_SOFT) begin
            m_ph <= PH_SOFT; m_el <= 0;
         end else if (m_ph == PH_REL && m_el + 1 == NS * GAP) begin
            m_ph <= PH_RUN; m_el <= 0;
         end else if (m_ph == PH_SOFT && m_el + 1 == HOLD) begin
            m_ph <= PH_REL; m_el <= 0;
         end else begin
            m_el <= m_el + 1;
         end
      end
   end

   function automatic logic [NS-1:0] exp_rstn();
      int k;
      if (m_ph == PH_RUN) return '1;
      if (m_ph != PH_REL) return '0;
      k = m_el / GAP + 1;
      if (k > NS) k = NS;
      return NS'((1 << k) - 1);
   endfunction

   function automatic logic exp_hb();
      return (m_ph == PH_RUN) ? (((m_el / HBD) % 2) == 1) : 1'b0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t got=%0h want=%0h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge fpga_clk) begin
      chk("m_rst_n", 32'(rst_n), 32'(exp_rstn()));
      chk("m_ready", 32'(sys_ready), 32'(m_ph == PH_RUN));
      chk("m_hb", 32'(heartbeat), 32'(exp_hb()));
      chk("m_fault", 32'(fault_cnt), 32'(m_fault));
   end

   task automatic mark();
      cur = 0;
   endtask

   task automatic goto(input int k);
      repeat (k - cur) @(posedge fpga_clk);
      #1;
      cur = k;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!sys_ready && n < 200) begin
         @(posedge fpga_clk); #1; n++;
      end
      chk("ready_timeout", 32'(sys_ready), 32'd1);
   endtask

   // Full power-up timing relative to a lock rise just after edge 0.
   task automatic check_seq();
      goto(10); chk("seq_r10", 32'(rst_n), 32'h0);
      goto(11); chk("seq_r11", 32'(rst_n), 32'h1);
      goto(14); chk("seq_r14", 32'(rst_n), 32'h1);
      goto(15); chk("seq_r15", 32'(rst_n), 32'h3);
      goto(18); chk("seq_r18", 32'(rst_n), 32'h3);
      goto(19); chk("seq_r19", 32'(rst_n), 32'h7);
      goto(23); chk("seq_r23", 32'(rst_n), 32'hF);
      goto(26); chk("seq_rdy26", 32'(sys_ready), 32'd0);
      goto(27); chk("seq_rdy27", 32'(sys_ready), 32'd1);
      goto(31); chk("seq_hb31", 32'(heartbeat), 32'd0);
      goto(32); chk("seq_hb32", 32'(heartbeat), 32'd1);
      goto(36); chk("seq_hb36", 32'(heartbeat), 32'd1);
      goto(37); chk("seq_hb37", 32'(heartbeat), 32'd0);
      goto(42); chk("seq_hb42", 32'(heartbeat), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog @%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge fpga_clk);
      #1;
      chk("rst_rstn", 32'(rst_n), 32'h0);
      chk("rst_ready", 32'(sys_ready), 32'd0);
      chk("rst_hb", 32'(heartbeat), 32'd0);
      chk("rst_fault", 32'(fault_cnt), 32'd0);
      fpga_rst = 1'b0;

      // Power-up
      @(posedge fpga_clk); #1; mark(); pll_locked = 1'b1;
      check_seq();

      // Lock loss in RUN, then relock repeats the sequence
      mark(); pll_locked = 1'b0;
      goto(2); chk("loss_r2", 32'(rst_n), 32'hF);
      goto(3);
      chk("loss_rstn", 32'(rst_n), 32'h0);
      chk("loss_ready", 32'(sys_ready), 32'd0);
      chk("loss_hb", 32'(heartbeat), 32'd0);
      chk("loss_fault", 32'(fault_cnt), 32'd1);
      mark(); pll_locked = 1'b1;
      check_seq();

      // Soft reset in RUN
      mark(); soft_rst_req = 1'b1;
      goto(1); soft_rst_req = 1'b0;
      chk("soft_r1", 32'(rst_n), 32'h0);
      chk("soft_rdy1", 32'(sys_ready), 32'd0);
      goto(6); chk("soft_r6", 32'(rst_n), 32'h0);
      goto(7); chk("soft_r7", 32'(rst_n), 32'h1);
      goto(11); chk("soft_r11", 32'(rst_n), 32'h3);
      chk("soft_fault", 32'(fault_cnt), 32'd1);
      wait_ready();

      // A request inside SOFT does not extend the hold
      @(posedge fpga_clk); #1; mark(); soft_rst_req = 1'b1;
      goto(1); soft_rst_req = 1'b0;
      goto(3); soft_rst_req = 1'b1;
      goto(4); soft_rst_req = 1'b0;
      goto(6); chk("ssoft_r6", 32'(rst_n), 32'h0);
      goto(7); chk("ssoft_r7", 32'(rst_n), 32'h1);
      wait_ready();

      // Collision: soft request on the same cycle lock_s drops
      @(posedge fpga_clk); #1; mark(); pll_locked = 1'b0;
      goto(2); soft_rst_req = 1'b1;
      goto(3); soft_rst_req = 1'b0;
      chk("col_r3", 32'(rst_n), 32'h0);
      chk("col_fault", 32'(fault_cnt), 32'd2);
      goto(10); chk("col_r10", 32'(rst_n), 32'h0);
      mark(); pll_locked = 1'b1;
      goto(11); chk("col_relock11", 32'(rst_n), 32'h1);
      goto(15); chk("col_relock15", 32'(rst_n), 32'h3);

      // Async reset mid-RELEASE after rst_n[1] rose
      #2; fpga_rst = 1'b1; pll_locked = 1'b0;
      #1;
      chk("arst_rstn", 32'(rst_n), 32'h0);
      chk("arst_ready", 32'(sys_ready), 32'd0);
      chk("arst_hb", 32'(heartbeat), 32'd0);
      chk("arst_fault", 32'(fault_cnt), 32'd0);
      repeat (3) @(posedge fpga_clk);
      #1; fpga_rst = 1'b0;
      repeat (3) @(posedge fpga_clk);
      #1;

      // Unstable lock: high 5, low 1, high again
      mark(); pll_locked = 1'b1;
      goto(5); pll_locked = 1'b0;
      goto(6); pll_locked = 1'b1;
      mark();
      goto(10); chk("unst_r10", 32'(rst_n), 32'h0);
      goto(11); chk("unst_r11", 32'(rst_n), 32'h1);
      chk("unst_fault", 32'(fault_cnt), 32'd0);
      wait_ready();

      // Fault counter saturation
      for (int i = 0; i < 255; i++) begin
         pll_locked = 1'b0;
         repeat (3) @(posedge fpga_clk);
         #1; pll_locked = 1'b1;
         wait_ready();
      end
      chk("sat_255", 32'(fault_cnt), 32'd255);
      pll_locked = 1'b0;
      repeat (3) @(posedge fpga_clk);
      #1;
      chk("sat_256", 32'(fault_cnt), 32'd255);
      chk("sat_rstn", 32'(rst_n), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpga_rst_seq.md
# fpga_rst_seq

Staged reset sequencer in the 20 MHz system domain, directly downstream of the board clock/reset generator. It synchronises the MMCM lock flag and qualifies it as stable, then releases a set of per-subsystem active-low resets one at a time at fixed intervals. Once every stage is released it raises `sys_ready` and drives a heartbeat LED. It re-enters reset on lock loss or on a software reset request, and counts lock-loss faults.

## Interface
Parameters:
- `STAGES`, 4: number of staged reset outputs (1–8).
- `LOCK_STABLE`, 1024: consecutive synchronised-lock-high cycles required before release.
- `STAGE_GAP`, 16: cycles between successive stage releases, and between the last stage and `sys_ready` (≥1).
- `SOFT_HOLD`, 64: cycles all resets are held for a software reset request (≥1).
- `HB_DIV`, 10000000: heartbeat half-period in cycles (1 Hz blink at 20 MHz).

Ports:
- `fpga_clk`, in, 1: 20 MHz system clock (buffered clock-generator output).
- `fpga_rst`, in, 1: asynchronous, active-high reset (inverted clock-generator reset output).
- `pll_locked`, in, 1: MMCM lock flag; asynchronous to `fpga_clk`.
- `soft_rst_req`, in, 1: synchronous single-cycle software reset request.
- `rst_n`, out, STAGES: staged active-low resets; bit 0 releases first.
- `sys_ready`, out, 1: all stages released, sequence complete.
- `heartbeat`, out, 1: LED drive, toggling in RUN only.
- `fault_cnt`, out, 8: saturating count of lock-loss events seen while in RUN.

## Operation
- `pll_locked` passes through a 2-FF synchroniser to give `lock_s`. Only `lock_s` is used.
- States: WAIT_LOCK, RELEASE, RUN, SOFT. All outputs are registered.
- WAIT_LOCK:
  - All `rst_n`=0, `sys_ready`=0.
  - The stable counter increments on each cycle with `lock_s`=1 and clears when `lock_s`=0.
  - When the counter reaches `LOCK_STABLE`, go to RELEASE.
- RELEASE:
  - `rst_n[0]` rises on the first RELEASE cycle.
  - `rst_n[k]` rises exactly `STAGE_GAP` cycles after `rst_n[k-1]`.
  - `STAGE_GAP` cycles after `rst_n[STAGES-1]` rises, `sys_ready` rises and the state becomes RUN.
  - Released bits stay high until the next reset entry.
- RUN:
  - Heartbeat counter runs; `heartbeat` toggles every `HB_DIV` cycles.
  - `heartbeat` is forced to 0 and the counter cleared in any other state.
- Lock loss (`lock_s`=0 in RELEASE, RUN or SOFT):
  - Next edge: all `rst_n`=0, `sys_ready`=0, state WAIT_LOCK, stable counter cleared.
  - `fault_cnt` increments only when the loss occurs in RUN, saturating at 255.
- `soft_rst_req`=1 in RELEASE or RUN:
  - Next edge: all `rst_n`=0, `sys_ready`=0, state SOFT.
  - After `SOFT_HOLD` cycles in SOFT, go to RELEASE directly; the lock is not requalified.
- `soft_rst_req` is ignored in WAIT_LOCK and SOFT; a request in SOFT does not extend the hold.
- Simultaneous lock loss and `soft_rst_req`: lock loss wins (WAIT_LOCK, fault counted if in RUN).
- Counter widths are `$clog2` of the largest parameter value plus 1; no wrap is reachable.

## Timing
- Reset values while `fpga_rst`=1:
  - outputs: `rst_n`=0, `sys_ready`=0, `heartbeat`=0, `fault_cnt`=0;
  - internal: synchroniser flops 0, state WAIT_LOCK, all counters 0.
- `fpga_rst` asserted mid-sequence forces the reset values immediately (asynchronous); there is no partial state retention.
- Lock qualification latency: `pll_locked`↑ (set just after edge 0) → `lock_s`↑ at edge 2 → `rst_n[0]`↑ at edge `2+LOCK_STABLE+1`.
- Reset entry (lock loss or soft request) is 1 cycle after detection. Lock loss adds 2 cycles of synchroniser delay from `pll_locked`↓.
- A lock glitch shorter than 1 cycle may be missed. Any loss seen on `lock_s` is always acted on.

## Test plan
Parameters for all scenarios: `STAGES`=4, `LOCK_STABLE`=8, `STAGE_GAP`=4, `SOFT_HOLD`=6, `HB_DIV`=5. Cycle 0 is the first edge after `pll_locked` changes.
- Power-up: release `fpga_rst`, then `pll_locked`=1 after cycle 0.
  - → `rst_n[0..3]` rise at cycles 11, 15, 19, 23; `sys_ready` rises at 27.
  - → `heartbeat` toggles at 32, 37, 42.
- Unstable lock: in WAIT_LOCK, `pll_locked` high 5 cycles, low 1, high again.
  - → stable counter restarts; `rst_n[0]` rises 11 cycles after the final rise.
  - → `fault_cnt` stays 0.
- Lock loss in RUN: drop `pll_locked`.
  - → within 3 cycles `rst_n`=0, `sys_ready`=0, `heartbeat`=0, `fault_cnt`=1.
  - → on relock, the full power-up sequence repeats.
- Soft reset: pulse `soft_rst_req` in RUN.
  - → next cycle `rst_n`=0; after 6 SOFT cycles `rst_n[0]` rises.
  - → later stages follow at 4-cycle spacing; `fault_cnt` is unchanged.
- Collision: `soft_rst_req` and lock loss on the same cycle in RUN → state WAIT_LOCK, `fault_cnt` increments. Separately, a soft request during SOFT does not extend the hold.
- Async reset mid-RELEASE, after `rst_n[1]` has risen: assert `fpga_rst` → all outputs 0 at once. `fault_cnt` saturation: 256 lock losses in RUN → reads 255.
